c2h_stream_checker: RTL and testbench

C2H_STREAM_CHECKER -- requirements
Module: c2h_stream_checker

---
 rtl/c2h_stream_checker_pkg.sv | 10 +
 rtl/c2h_stream_checker_pattern_gen.sv | 23 ++
 rtl/c2h_stream_checker.sv | 129 ++++++++++++
 tb/tb_c2h_stream_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2h_stream_checker_pkg.sv
// Shared definitions for the C2H stream checker: FSM encoding and pattern word width.
package c2h_stream_checker_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/c2h_stream_checker_pattern_gen.sv
// Expected-beat generator: word i of the beat is (seed + beat index + i) mod 2^32.
module c2h_pattern_gen
  import c2h_stream_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16
) (
  input  logic [31:0]           seed,
  input  logic [LEN_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] pattern
);
  localparam int NUM_WORDS = DATA_WIDTH / WORD_W;

  logic [31:0] base;

  always_comb begin
    base    = seed + 32'(idx);
    pattern = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      pattern[i*WORD_W +: WORD_W] = base + 32'(i);
    end
  end
endmodule

// File: rtl/c2h_stream_checker.sv
// C2H stream checker: compares accepted beats against a seeded counting pattern and
// keeps beat/packet/mismatch statistics plus sticky tlast/tkeep protocol flags.
module c2h_stream_checker
  import c2h_stream_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]    cfg_num_pkts,
  input  logic [31:0]             cfg_seed,
  input  logic [3:0]              cfg_throttle,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                    S_AXIS_tvalid,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tlast,
  output logic                    S_AXIS_tready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    mism_cnt,
  output logic                    tlast_err,
  output logic                    keep_err,
  output logic [CNT_WIDTH-1:0]    first_mism_beat,
  output logic [DATA_WIDTH-1:0]   first_mism_data,
  output state_t                  dbg_state
);
  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
  // tready is a function of registered state only, never of tvalid.
  state_t               state;
  logic [3:0]           thr_cnt;
  logic [3:0]           thr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] npk_q;
  logic [LEN_WIDTH-1:0] run_pkts;
  logic [LEN_WIDTH-1:0] idx;
  logic [31:0]          seed_q;
  logic [DATA_WIDTH-1:0] expected;
  logic accept, is_last, run_end;

  c2h_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_gen (
    .seed    (seed_q),
    .idx     (idx),
    .pattern (expected)
  );

  assign S_AXIS_tready = (state == ST_RUN) && ((thr_q == 4'd0) || (thr_cnt != 4'd0));
  assign accept        = S_AXIS_tvalid && S_AXIS_tready;
  assign is_last       = (idx == len_q - LEN_WIDTH'(1));
  assign run_end       = is_last && (npk_q != '0) && (run_pkts == npk_q - LEN_WIDTH'(1));
  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      thr_cnt         <= '0;
      thr_q           <= '0;
      len_q           <= '0;
      npk_q           <= '0;
      run_pkts        <= '0;
      idx             <= '0;
      seed_q          <= '0;
      beat_cnt        <= '0;
      pkt_cnt         <= '0;
      mism_cnt        <= '0;
      tlast_err       <= 1'b0;
      keep_err        <= 1'b0;
      first_mism_beat <= '0;
      first_mism_data <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_RUN;
            thr_cnt         <= '0;
            thr_q           <= cfg_throttle;
            len_q           <= (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
            npk_q           <= cfg_num_pkts;
            run_pkts        <= '0;
            idx             <= '0;
            seed_q          <= cfg_seed;
            beat_cnt        <= '0;
            pkt_cnt         <= '0;
            mism_cnt        <= '0;
            tlast_err       <= 1'b0;
            keep_err        <= 1'b0;
            first_mism_beat <= '0;
            first_mism_data <= '0;
          end
        end
        ST_RUN: begin
          // Counter runs 0..N; the single cycle at 0 is the backpressure slot.
          if (thr_q == 4'd0 || thr_cnt == thr_q) thr_cnt <= '0;
          else                                   thr_cnt <= thr_cnt + 4'd1;
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (S_AXIS_tdata != expected) begin
              if (mism_cnt != '1) mism_cnt <= mism_cnt + CNT_WIDTH'(1);
              if (mism_cnt == '0) begin
                first_mism_beat <= beat_cnt;
                first_mism_data <= S_AXIS_tdata;
              end
            end
            if (S_AXIS_tlast != is_last) tlast_err <= 1'b1;
            if (S_AXIS_tkeep != '1)      keep_err  <= 1'b1;
            if (is_last) begin
              pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
              run_pkts <= run_pkts + LEN_WIDTH'(1);
              idx      <= '0;
              seed_q   <= seed_q + 32'(len_q);
            end else begin
              idx <= idx + LEN_WIDTH'(1);
            end
          end
          if ((accept && run_end) || abort) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2h_stream_checker.sv
// Directed bench for c2h_stream_checker: table of whole-run vectors plus hand sequences
// for throttling, abort, start/abort collision and mid-packet reset.
module tb_c2h_stream_checker;
  import c2h_stream_checker_pkg::*;

  localparam int DW = 128;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [LW-1:0] cfg_pkt_len, cfg_num_pkts;
  logic [31:0]   cfg_seed;
  logic [3:0]    cfg_throttle;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic [DW/8-1:0] tkeep;
  logic          busy, done, tlast_err, keep_err;
  logic [CW-1:0] beat_cnt, pkt_cnt, mism_cnt, first_mism_beat;
  logic [DW-1:0] first_mism_data;
  state_t        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_fd;

  typedef struct {
    logic [LW-1:0] len;
    logic [LW-1:0] npk;
    logic [31:0]   seed;
    logic [3:0]    thr;
    int corrupt;
    int tl_bad;
    int kp_bad;
    int n_beats;
    int exp_beat;
    int exp_pkt;
    int exp_mism;
    int exp_fb;
    bit exp_tl;
    bit exp_kp;
    int exp_cycles;
  } vec_t;

  vec_t vecs[6];
  vec_t hv;

  c2h_stream_checker #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_pkt_len     (cfg_pkt_len),
    .cfg_num_pkts    (cfg_num_pkts),
    .cfg_seed        (cfg_seed),
    .cfg_throttle    (cfg_throttle),
    .abort           (abort),
    .S_AXIS_tdata    (tdata),
    .S_AXIS_tvalid   (tvalid),
    .S_AXIS_tkeep    (tkeep),
    .S_AXIS_tlast    (tlast),
    .S_AXIS_tready   (tready),
    .busy            (busy),
    .done            (done),
    .beat_cnt        (beat_cnt),
    .pkt_cnt         (pkt_cnt),
    .mism_cnt        (mism_cnt),
    .tlast_err       (tlast_err),
    .keep_err        (keep_err),
    .first_mism_beat (first_mism_beat),
    .first_mism_data (first_mism_data),
    .dbg_state       (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [31:0] s, input int idx);
    logic [DW-1:0] r;
    logic [31:0]   base;
    base = s + 32'(idx);
    r = '0;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic do_start(input vec_t v);
    @(negedge clk);
    cfg_pkt_len  = v.len;
    cfg_num_pkts = v.npk;
    cfg_seed     = v.seed;
    cfg_throttle = v.thr;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  // Source model: holds tvalid high, advances on each accepting edge.
  task automatic drive(input vec_t v, input bit abort_last, output int cycles);
    int b, idx, budget;
    logic [31:0] ws;
    int el;
    bit acc;
    el = (v.len == 0) ? 1 : int'(v.len);
    b = 0; idx = 0; ws = v.seed; cycles = 0; budget = 0;
    exp_fd = '0;
    while (b < v.n_beats && budget < 200) begin
      @(negedge clk);
      tdata = model(ws, idx);
      if (b == v.corrupt) begin
        tdata[3*32 +: 32] = tdata[3*32 +: 32] ^ 32'hDEAD_BEEF;
        exp_fd = tdata;
      end
      tlast = (idx == el - 1);
      if (b == v.tl_bad) tlast = !tlast;
      tkeep  = (b == v.kp_bad) ? '0 : '1;
      tvalid = 1'b1;
      acc    = tready;
      abort  = abort_last && acc && (b == v.n_beats - 1);
      chk("done_before_last", DW'(done), DW'(0));
      @(posedge clk);
      cycles++;
      budget++;
      if (acc) begin
        b++;
        if (idx == el - 1) begin
          idx = 0;
          ws  = ws + 32'(el);
        end else begin
          idx++;
        end
      end
    end
    if (budget >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", b, v.n_beats);
    end
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic check_results(input vec_t v, input string tag);
    chk({tag, "_beat_cnt"}, DW'(beat_cnt), DW'(v.exp_beat));
    chk({tag, "_pkt_cnt"},  DW'(pkt_cnt),  DW'(v.exp_pkt));
    chk({tag, "_mism_cnt"}, DW'(mism_cnt), DW'(v.exp_mism));
    chk({tag, "_first_beat"}, DW'(first_mism_beat), DW'(v.exp_fb));
    chk({tag, "_first_data"}, first_mism_data, exp_fd);
    chk({tag, "_tlast_err"}, DW'(tlast_err), DW'(v.exp_tl));
    chk({tag, "_keep_err"},  DW'(keep_err),  DW'(v.exp_kp));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    do_start(v);
    drive(v, 1'b0, cyc);
    @(negedge clk);
    chk({tag, "_done"}, DW'(done), DW'(1));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    check_results(v, tag);
    if (v.exp_cycles > 0) chk({tag, "_cycles"}, DW'(cyc), DW'(v.exp_cycles));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"},  DW'(dbg_state), DW'(ST_IDLE));
    chk({tag, "_tready"}, DW'(tready), DW'(0));
    chk({tag, "_busy"},   DW'(busy), DW'(0));
    chk({tag, "_done"},   DW'(done), DW'(0));
    chk({tag, "_cnts"},   DW'({beat_cnt, pkt_cnt, mism_cnt}), DW'(0));
    chk({tag, "_flags"},  DW'({tlast_err, keep_err}), DW'(0));
    chk({tag, "_first"},  first_mism_data | DW'(first_mism_beat), DW'(0));
  endtask

  initial begin
    int cyc;
    //           len   npk   seed           thr  cor tlb kpb nb  beat pkt mis fb tl kp cyc
    vecs[0] = '{16'd4, 16'd2, 32'h0000_0100, 4'd0, -1, -1, -1, 8, 8, 2, 0, 0, 0, 0, 8};
    vecs[1] = '{16'd4, 16'd2, 32'h0000_0100, 4'd0,  5, -1, -1, 8, 8, 2, 1, 5, 0, 0, 8};
    vecs[2] = '{16'd4, 16'd2, 32'h0000_0100, 4'd0, -1,  2, -1, 8, 8, 2, 0, 0, 1, 0, 8};
    vecs[3] = '{16'd4, 16'd2, 32'h0000_0100, 4'd3, -1, -1,  1, 8, 8, 2, 0, 0, 0, 1, 11};
    vecs[4] = '{16'd0, 16'd3, 32'hFFFF_FFFE, 4'd0, -1, -1, -1, 3, 3, 3, 0, 0, 0, 0, 3};
    vecs[5] = '{16'd3, 16'd2, 32'h7FFF_FFFF, 4'd1,  4, -1, -1, 6, 6, 2, 1, 4, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_pkt_len = '0; cfg_num_pkts = '0; cfg_seed = '0; cfg_throttle = '0;
    tdata = '0; tvalid = 1'b0; tkeep = '0; tlast = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Throttle 3 with no traffic: tready low on the first RUN cycle, then 3 high / 1 low.
    hv = vecs[3];
    do_start(hv);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("thr_tready_%0d", k), DW'(tready), DW'((k % 4) != 0));
    end
    pulse_abort();
    @(negedge clk);
    chk("thr_abort_done", DW'(done), DW'(1));
    chk("thr_abort_beats", DW'(beat_cnt), DW'(0));

    // Unbounded run ended by abort after 6 beats.
    hv = '{16'd4, 16'd0, 32'h0000_0020, 4'd0, -1, -1, -1, 6, 6, 1, 0, 0, 0, 0, 0};
    do_start(hv);
    drive(hv, 1'b0, cyc);
    @(negedge clk);
    chk("unb_still_busy", DW'(busy), DW'(1));
    pulse_abort();
    @(negedge clk);
    chk("unb_done", DW'(done), DW'(1));
    check_results(hv, "unb");

    // Abort coincident with an accepted beat: that beat still counts.
    hv = '{16'd4, 16'd0, 32'h0000_0020, 4'd0, -1, -1, -1, 3, 3, 0, 0, 0, 0, 0, 0};
    do_start(hv);
    drive(hv, 1'b1, cyc);
    @(negedge clk);
    chk("abacc_done", DW'(done), DW'(1));
    check_results(hv, "abacc");

    // start and abort together in DONE: start wins and clears the counters.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("collide_busy", DW'(busy), DW'(1));
    chk("collide_beats", DW'(beat_cnt), DW'(0));

    // Reset in the middle of a packet, then a clean run from index 0.
    pulse_abort();
    hv = vecs[0];
    hv.n_beats = 2;
    do_start(hv);
    drive(hv, 1'b0, cyc);
    @(negedge clk);
    chk("pre_reset_beats", DW'(beat_cnt), DW'(2));
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
